// File: rtl/toggle_pkg.sv
// Shared definitions for toggle-encoded event link receivers.
package toggle_pkg;

    // Decoder FSM: PRIME settles the synchronizer, RUN detects edges.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } dec_state_t;

    // Legal synchronizer depth range.
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    // True when a synchronizer depth is within the supported range.
    function automatic logic sync_stages_ok(input int n);
        return (n >= SYNC_MIN) && (n <= SYNC_MAX);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/toggle_pulse_decoder.sv
// Receive-side decoder for toggle-encoded events: synchronizes the line,
// turns each transition into a one-cycle pulse and keeps a saturating
// pending count that a consumer drains via valid/ready.
module toggle_pulse_decoder
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             enable,
    input  logic             clear,
    output logic             evt_pulse,
    output logic             pend_valid,
    input  logic             pend_ready,
    output logic [CNT_W-1:0] pend_count,
    output logic             overflow,
    output logic             phase
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Prime ends once the synchronizer output reflects a level sampled after
    // reset release, so a line held high through reset is not an edge.
    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("toggle_pulse_decoder: SYNC_STAGES out of range");
    end

    logic             w_s;
    logic             w_edge;
    logic             w_accept;
    logic             w_take;
    logic [CNT_W-1:0] w_count_d;
    logic             w_overflow_d;

    dec_state_t       r_state;
    logic [2:0]       r_prime_cnt;
    logic             r_last_level;
    logic             r_evt_pulse;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (w_s)
    );

    assign w_edge   = (r_state == RUN) && (w_s != r_last_level);
    assign w_accept = w_edge && enable && !clear;
    assign w_take   = (r_count != '0) && pend_ready;

    // FSM: prime the synchronizer, then track the last seen level every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= PRIME;
            r_prime_cnt  <= '0;
            r_last_level <= 1'b0;
        end else if (r_state == PRIME) begin
            if (r_prime_cnt == PRIME_LAST) begin
                r_last_level <= w_s;
                r_state      <= RUN;
            end else begin
                r_prime_cnt <= r_prime_cnt + 3'd1;
            end
        end else begin
            r_last_level <= w_s;
        end
    end

    // Next pending count and overflow, clear first, then event/drain priority.
    always_comb begin
        w_count_d    = r_count;
        w_overflow_d = r_overflow;
        if (clear) begin
            w_count_d    = '0;
            w_overflow_d = 1'b0;
        end else if (w_accept && w_take) begin
            w_count_d = r_count;
        end else if (w_accept) begin
            if (r_count != CNT_MAX) begin
                w_count_d = r_count + 1'b1;
            end else begin
                w_overflow_d = 1'b1;
            end
        end else if (w_take) begin
            w_count_d = r_count - 1'b1;
        end
    end

    // Register the pulse, pending count and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_pulse <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_evt_pulse <= w_accept;
            r_count     <= w_count_d;
            r_overflow  <= w_overflow_d;
        end
    end

    assign evt_pulse  = r_evt_pulse;
    assign pend_valid = (r_count != '0);
    assign pend_count = r_count;
    assign overflow   = r_overflow;
    assign phase      = w_s;

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Scoreboard bench for toggle_pulse_decoder: each toggle that should produce
// an event queues the expected pulse cycle and count; a monitor checks pulses.
module tb_toggle_pulse_decoder;

    localparam int SYNC  = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             t_in;
    logic             enable;
    logic             clear;
    logic             pend_ready;
    logic             evt_pulse;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_count;
    logic             overflow;
    logic             phase;

    toggle_pulse_decoder #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .t_in       (t_in),
        .enable     (enable),
        .clear      (clear),
        .evt_pulse  (evt_pulse),
        .pend_valid (pend_valid),
        .pend_ready (pend_ready),
        .pend_count (pend_count),
        .overflow   (overflow),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release.
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int cyc;
        int cnt;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge: the transition is captured on the next rising
    // edge and the pulse appears SYNC edges after that.
    task automatic toggle_expect(input int cnt, input int ovf);
        exp_t e;
        t_in  = ~t_in;
        e.cyc = cyc + 1 + SYNC;
        e.cnt = cnt;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic toggle_only();
        t_in = ~t_in;
    endtask

    // Monitor: compare every pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                check("missed_pulse", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (evt_pulse) begin
                exp_t e;
                pulses++;
                check("pulse_expected", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_count", int'(pend_count), e.cnt);
                    check("pulse_overflow", int'(overflow), e.ovf);
                    check("pulse_valid", int'(pend_valid), (e.cnt != 0) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        t_in       = 1'b1;
        reset      = 1'b1;
        enable     = 1'b1;
        clear      = 1'b0;
        pend_ready = 1'b0;
        tick(3);
        check("reset_pulse", int'(evt_pulse), 0);
        check("reset_count", int'(pend_count), 0);
        check("reset_valid", int'(pend_valid), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_phase", int'(phase), 0);

        // Line held high through reset: phase follows, no event.
        reset = 1'b0;
        tick(2);
        check("phase_after_release", int'(phase), 1);
        check("count_after_release", int'(pend_count), 0);

        // Latency: toggle captured on edge 10, pulse on edge 12.
        while (cyc < 9) tick(1);
        check("no_spurious_pulse", pulses, 0);
        toggle_expect(1, 0);
        tick(4);
        check("latency_count", int'(pend_count), 1);
        check("latency_valid", int'(pend_valid), 1);
        check("pulse_one_cycle", int'(evt_pulse), 0);

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_count", int'(pend_count), 0);

        // Saturation: 17 events into a 4-bit counter.
        p0 = pulses;
        for (int i = 1; i <= 17; i++) begin
            toggle_expect((i > 15) ? 15 : i, (i > 15) ? 1 : 0);
            tick(3);
        end
        tick(2);
        check("sat_pulses", pulses - p0, 17);
        check("sat_count", int'(pend_count), 15);
        check("sat_overflow", int'(overflow), 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("sat_clear_count", int'(pend_count), 0);
        check("sat_clear_overflow", int'(overflow), 0);
        check("sat_clear_valid", int'(pend_valid), 0);

        // Handshake while empty must not underflow.
        pend_ready = 1'b1;
        tick(2);
        pend_ready = 1'b0;
        check("empty_drain_count", int'(pend_count), 0);

        // Build count of 3, then event and drain on the same edge.
        for (int i = 1; i <= 3; i++) begin
            toggle_expect(i, 0);
            tick(3);
        end
        tick(2);
        check("build_count", int'(pend_count), 3);
        toggle_expect(3, 0);
        tick(2);
        pend_ready = 1'b1;
        tick(1);
        pend_ready = 1'b0;
        tick(2);
        check("simul_count", int'(pend_count), 3);
        pend_ready = 1'b1;
        tick(1);
        pend_ready = 1'b0;
        check("drain_one_count", int'(pend_count), 2);

        // Enable gating: transitions while disabled are discarded.
        p0 = pulses;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            toggle_only();
            tick(3);
        end
        tick(3);
        enable = 1'b1;
        tick(3);
        check("disabled_pulses", pulses - p0, 0);
        check("disabled_count", int'(pend_count), 2);
        toggle_expect(3, 0);
        tick(5);
        check("reenable_count", int'(pend_count), 3);

        // Clear in the cycle the edge is detected wins over the event.
        p0 = pulses;
        toggle_only();
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(2);
        check("collision_pulses", pulses - p0, 0);
        check("collision_count", int'(pend_count), 0);
        toggle_expect(1, 0);
        tick(5);
        check("post_collision_count", int'(pend_count), 1);

        // Reset mid-operation drops the pending count.
        reset = 1'b1;
        tick(1);
        check("midreset_count", int'(pend_count), 0);
        check("midreset_valid", int'(pend_valid), 0);
        reset = 1'b0;
        tick(6);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
